// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
// Memory access modes, datapath widths and fetch bundle types.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [2:0] MEM_MODE_WORD = 3'b100;
    localparam logic [2:0] MEM_MODE_HALF = 3'b010;
    localparam logic [2:0] MEM_MODE_BYTE = 3'b001;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        F_RUN  = 1'b0,
        F_HALT = 1'b1
    } fstate_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} between fetch and decode.
// Flush wins over push/pop; the head is always entry 0.
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t e0_q;
    fetch_entry_t e1_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop & (cnt_q != 2'd0);
    assign do_push = push & ((cnt_q != 2'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= din;
                    else               e1_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // count unchanged; the new entry lands behind the survivor
                    if (cnt_q == 2'd1) begin
                        e0_q <= din;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head       = e0_q;
    assign head_valid = (cnt_q != 2'd0);
    assign count      = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instr_ram request, redirect handling.
// FETCH_MISALIGN_CHECK_EN adds fetch_fault and halt on misaligned redirects.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_we,
    output logic [2:0]         imem_mode,
    output logic [XLEN-1:0]    imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               fetch_fault
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target;
    logic            halted;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [1:0]      count;
    fetch_entry_t    din;
    fetch_entry_t    head;

    assign imem_we    = 1'b0;
    assign imem_mode  = MEM_MODE_WORD;
    assign imem_addr  = pc_q;
    assign imem_wdata = '0;

    assign pop  = head_valid & out_ready;
    assign push = ~redirect_valid & ~halted
                & ((count < 2'(DEPTH)) | pop);

    assign din.pc    = pc_q;
    assign din.instr = imem_rdata;

`ifdef FETCH_MISALIGN_CHECK_EN
    fstate_t state_q;
    fstate_t state_d;
    logic    misalign;

    assign target   = redirect_pc;
    assign misalign = |redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= F_RUN;
        else     state_q <= state_d;
    end

    // Only a redirect can leave or enter the halted state
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = misalign ? F_HALT : F_RUN;
        end
    end

    assign halted      = (state_q == F_HALT);
    assign fetch_fault = halted;
`else
    assign target = redirect_pc & ~32'h3;
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= target;
        end else if (push) begin
            pc_q <= next_pc(pc_q);
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .din        (din),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign out_valid = head_valid;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule
